uart_mmio: RTL

//  Memory-mapped 8N1 UART peripheral at 082h-084h on the CPU data bus, downstream of cpu.

---
 rtl/uart_mmio.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: data register at BASE_ADDR, status at BASE_ADDR+2.
// Independent TX and RX state machines; read data is registered one cycle after the address.
module uart_mmio #(
  parameter int                    CLOCK_HZ   = 27_000_000,
  parameter int                    BAUD       = 115200,
  parameter int                    ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h082
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  wr_mem,
  input  logic                  byt,
  input  logic [15:0]           wr_data,
  output logic [15:0]           rd_data,
  output logic                  uart_tx,
  input  logic                  uart_rx,
  output logic                  tx_busy
);

  localparam int BIT_DIV  = CLOCK_HZ / BAUD;
  localparam int HALF_DIV = BIT_DIV / 2;
  localparam int CW       = $clog2(BIT_DIV);
  localparam logic [CW-1:0] DIV_LAST  = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);
  localparam logic [ADDR_WIDTH-1:0] STS_ADDR = BASE_ADDR + ADDR_WIDTH'(2);

  // Both register windows are two bytes wide, so decode ignores address bit 0.
  logic hit_dat, hit_sts, rd_dat, rd_sts, wr_dat;
  logic [7:0] wr_byte;

  assign hit_dat = (mem_addr[ADDR_WIDTH-1:1] == BASE_ADDR[ADDR_WIDTH-1:1]);
  assign hit_sts = (mem_addr[ADDR_WIDTH-1:1] == STS_ADDR[ADDR_WIDTH-1:1]);
  assign rd_dat  = ~wr_mem & hit_dat;
  assign rd_sts  = ~wr_mem & hit_sts;
  assign wr_dat  = wr_mem & hit_dat;
  assign wr_byte = mem_addr[0] ? wr_data[15:8] : wr_data[7:0];

  logic [7:0] rx_data;
  logic       rx_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= 16'h0000;
    end else if (rd_dat) begin
      rd_data <= (byt & mem_addr[0]) ? 16'h00fe : {8'hfe, rx_data};
    end else if (rd_sts) begin
      rd_data <= {14'd0, rx_valid, tx_busy};
    end else begin
      rd_data <= 16'h0000;
    end
  end

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  tx_state_t      tx_state;
  logic [CW-1:0]  tx_cnt;
  logic [2:0]     tx_idx;
  logic [7:0]     tx_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_cnt   <= '0;
      tx_idx   <= 3'd0;
      tx_shift <= 8'h00;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (wr_dat) begin
            tx_shift <= wr_byte;
            tx_state <= TX_START;
            uart_tx  <= 1'b0;
            tx_busy  <= 1'b1;
            tx_cnt   <= '0;
          end
        end
        TX_START: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt   <= '0;
            tx_idx   <= 3'd0;
            uart_tx  <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt <= '0;
            if (tx_idx == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              // Line already carries shift[0]; present the next bit as we shift.
              tx_idx   <= tx_idx + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              uart_tx  <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt   <= '0;
            tx_busy  <= 1'b0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
  rx_state_t      rx_state;
  logic [CW-1:0]  rx_cnt;
  logic [2:0]     rx_idx;
  logic [7:0]     rx_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= 3'd0;
      rx_shift <= 8'h00;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else begin
      // A completing byte below overrides this clear in the same cycle.
      if (rd_dat) begin
        rx_valid <= 1'b0;
      end
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev & ~rx_sync) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_idx   <= 3'd0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_idx == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              rx_idx <= rx_idx + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt <= '0;
            if (rx_sync) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_WAIT_HIGH;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_sync) begin
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule
